// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port synchronous SRAM between the VGA pixel
// fetcher (display port) and the image-update engine (host port).
// At most one SRAM access issues per cycle. Read data returns one cycle later
// to whichever port issued the read.
// The display port normally always wins arbitration.
// Optional feature macro: STARVE_GUARD_EN. When it is defined, a host that has
// waited MAX_WAIT cycles is granted over the display. The dropped display
// request is flagged on disp_miss.
module sram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 15,
    parameter int WAIT_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_valid,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    output logic                  disp_miss,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_DISP    = 2'd1,
        OWN_HOST_RD = 2'd2
    } owner_t;

    owner_t                owner_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [DATA_WIDTH-1:0] disp_hold_q;
    logic [DATA_WIDTH-1:0] host_hold_q;
    logic                  force_host;
    logic                  host_win;
    logic                  disp_win;

    if (MAX_WAIT >= (1 << WAIT_W)) begin : g_bad_max_wait
        $error("sram_arbiter: MAX_WAIT must be below 2**WAIT_W");
    end

`ifdef STARVE_GUARD_EN
    assign force_host = host_req && (wait_cnt == WAIT_W'(MAX_WAIT));
`else
    assign force_host = 1'b0;
`endif

    assign host_win  = host_req && (!disp_req || force_host);
    assign disp_win  = disp_req && !force_host;
    assign host_gnt  = host_win;
    assign disp_miss = disp_req && force_host;

    // Drive the SRAM from this cycle's arbitration winner; an idle bus is all zero
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (host_win) begin
            sram_en    = 1'b1;
            sram_we    = host_we;
            sram_addr  = host_addr;
            sram_wdata = host_wdata;
        end else if (disp_win) begin
            sram_en    = 1'b1;
            sram_addr  = disp_addr;
        end
    end

    // Remember who owns the read data that the SRAM will present next cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
        end else if (disp_win) begin
            owner_q <= OWN_DISP;
        end else if (host_win && !host_we) begin
            owner_q <= OWN_HOST_RD;
        end else begin
            owner_q <= OWN_NONE;
        end
    end

    // Count how long the host has been kept waiting, saturating at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (host_req && !host_win) begin
            if (wait_cnt != {WAIT_W{1'b1}}) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Keep the last word each port received so its rdata holds between responses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_hold_q <= '0;
            host_hold_q <= '0;
        end else begin
            if (owner_q == OWN_DISP) begin
                disp_hold_q <= sram_rdata;
            end
            if (owner_q == OWN_HOST_RD) begin
                host_hold_q <= sram_rdata;
            end
        end
    end

    // Route the SRAM's registered read data to the port that issued the read
    always_comb begin
        disp_valid  = (owner_q == OWN_DISP);
        host_rvalid = (owner_q == OWN_HOST_RD);
        disp_rdata  = disp_valid  ? sram_rdata : disp_hold_q;
        host_rdata  = host_rvalid ? sram_rdata : host_hold_q;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random stimulus for sram_arbiter, with a
// behavioural SRAM and a reference model that predicts every output each cycle.
// Follows STARVE_GUARD_EN the same way the design does.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int DW       = 8;
    localparam int AW       = 16;
    localparam int MAX_WAIT = 15;
    localparam int WAIT_W   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_valid;
    logic [DW-1:0] disp_rdata;
    logic          disp_miss;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem  [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    sram_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_WAIT  (MAX_WAIT),
        .WAIT_W    (WAIT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_rdata (disp_rdata),
        .disp_miss  (disp_miss),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous SRAM, one-cycle registered read, write-first
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                sram_mem[sram_addr] = sram_wdata;
                sram_rdata <= sram_wdata;
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic dr, input logic [AW-1:0] da, input logic hr,
                                 input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        @(posedge clk);
        #1;
        disp_req   = dr;
        disp_addr  = da;
        host_req   = hr;
        host_we    = hw;
        host_addr  = ha;
        host_wdata = hd;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Reference model state: pending responses, last delivered words, host wait length
    logic          m_disp_pend = 1'b0;
    logic          m_host_pend = 1'b0;
    logic          m_hold      = 1'b0;
    logic [DW-1:0] m_disp_data = '0;
    logic [DW-1:0] m_host_data = '0;
    logic [DW-1:0] m_last_disp = '0;
    logic [DW-1:0] m_last_host = '0;
    int            m_wait      = 0;
    logic          e_starve;
    logic          e_hgnt;
    logic          e_dsrv;
    logic [AW-1:0] e_addr;

    // Compare every output against the reference model once per cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("rst_disp_valid",  32'(disp_valid),  32'd0);
            checkOutput("rst_host_rvalid", 32'(host_rvalid), 32'd0);
            checkOutput("rst_disp_miss",   32'(disp_miss),   32'd0);
            checkOutput("rst_disp_rdata",  32'(disp_rdata),  32'd0);
            checkOutput("rst_host_rdata",  32'(host_rdata),  32'd0);
            m_disp_pend = 1'b0;
            m_host_pend = 1'b0;
            m_hold      = 1'b0;
            m_last_disp = '0;
            m_last_host = '0;
            m_wait      = 0;
        end else begin
            if (m_disp_pend) m_last_disp = m_disp_data;
            if (m_host_pend) m_last_host = m_host_data;
            checkOutput("disp_valid",  32'(disp_valid),  32'(m_disp_pend));
            checkOutput("disp_rdata",  32'(disp_rdata),  32'(m_last_disp));
            checkOutput("host_rvalid", 32'(host_rvalid), 32'(m_host_pend));
            checkOutput("host_rdata",  32'(host_rdata),  32'(m_last_host));
            if (m_hold) checkOutput("host_req_held_until_gnt", 32'(host_req), 32'd1);

`ifdef STARVE_GUARD_EN
            e_starve = host_req && (m_wait == MAX_WAIT);
`else
            e_starve = 1'b0;
`endif
            e_hgnt = host_req && (!disp_req || e_starve);
            e_dsrv = disp_req && !e_hgnt;
            e_addr = e_hgnt ? host_addr : (e_dsrv ? disp_addr : '0);
            checkOutput("host_gnt",  32'(host_gnt),  32'(e_hgnt));
            checkOutput("disp_miss", 32'(disp_miss), 32'(disp_req && e_hgnt));
            checkOutput("sram_en",   32'(sram_en),   32'(e_hgnt || e_dsrv));
            checkOutput("sram_we",   32'(sram_we),   32'(e_hgnt && host_we));
            checkOutput("sram_addr", 32'(sram_addr), 32'(e_addr));
            if (e_hgnt && host_we) checkOutput("sram_wdata", 32'(sram_wdata), 32'(host_wdata));
            if (!(e_hgnt || e_dsrv)) checkOutput("sram_wdata_idle", 32'(sram_wdata), 32'd0);

            m_disp_pend = e_dsrv;
            m_disp_data = ref_mem[disp_addr];
            m_host_pend = e_hgnt && !host_we;
            m_host_data = ref_mem[host_addr];
            if (e_hgnt && host_we) ref_mem[host_addr] = host_wdata;
            m_hold = host_req && !e_hgnt;
            if (m_hold) m_wait = (m_wait < (1 << WAIT_W) - 1) ? m_wait + 1 : m_wait;
            else        m_wait = 0;
        end
    end

    initial begin
        logic          h_hold;
        logic          dr;
        logic          hr;
        logic          hw;
        logic [AW-1:0] da;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        int            grants;
        int            gnt_cycle;

        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = 8'(i * 37 + (i >> 8));
            ref_mem[i]  = 8'(i * 37 + (i >> 8));
        end
        sram_mem[16'h0010] = 8'h5A;
        ref_mem[16'h0010]  = 8'h5A;

        idle();
        idle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_disp_valid", 32'(disp_valid), 32'd0);
        checkOutput("post_reset_sram_en",    32'(sram_en),    32'd0);

        // Display read of a preloaded word
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
        checkOutput("t1_sram_en",   32'(sram_en),   32'd1);
        checkOutput("t1_sram_addr", 32'(sram_addr), 32'h0010);
        idle();
        checkOutput("t1_disp_valid", 32'(disp_valid), 32'd1);
        checkOutput("t1_disp_rdata", 32'(disp_rdata), 32'h5A);
        idle();
        checkOutput("t1_disp_valid_drop", 32'(disp_valid), 32'd0);
        checkOutput("t1_disp_rdata_hold", 32'(disp_rdata), 32'h5A);

        // Host write then read back of the same address
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 16'h1234, 8'hC3);
        checkOutput("t2_wr_gnt",   32'(host_gnt),   32'd1);
        checkOutput("t2_wr_we",    32'(sram_we),    32'd1);
        checkOutput("t2_wr_addr",  32'(sram_addr),  32'h1234);
        checkOutput("t2_wr_wdata", 32'(sram_wdata), 32'hC3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h1234, '0);
        checkOutput("t2_rd_gnt", 32'(host_gnt), 32'd1);
        checkOutput("t2_rd_we",  32'(sram_we),  32'd0);
        idle();
        checkOutput("t2_host_rvalid", 32'(host_rvalid), 32'd1);
        checkOutput("t2_host_rdata",  32'(host_rdata),  32'hC3);

        // Contention: display wins three cycles, host granted on the fourth
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0030, '0);
            checkOutput("t3_host_waits", 32'(host_gnt),  32'd0);
            checkOutput("t3_disp_addr",  32'(sram_addr), 32'h0020);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0030, '0);
        checkOutput("t3_host_gnt_4th", 32'(host_gnt),   32'd1);
        checkOutput("t3_disp_rdata",   32'(disp_rdata), 32'hA0);
        idle();
        checkOutput("t3_host_rdata", 32'(host_rdata), 32'hF0);

`ifdef STARVE_GUARD_EN
        // Display stuck high: host forced through after MAX_WAIT cycles of waiting
        gnt_cycle = 0;
        for (int k = 1; k <= 20 && gnt_cycle == 0; k++) begin
            applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, '0);
            if (host_gnt) begin
                gnt_cycle = k;
                checkOutput("t4_disp_miss_with_gnt", 32'(disp_miss), 32'd1);
            end
        end
        checkOutput("t4_forced_gnt_cycle", 32'(gnt_cycle), 32'd16);
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, '0, '0);
        checkOutput("t4_no_disp_valid_after_miss", 32'(disp_valid),  32'd0);
        checkOutput("t4_host_rvalid",              32'(host_rvalid), 32'd1);
        checkOutput("t4_host_rdata",               32'(host_rdata),  32'h02);
        idle();
`else
        // Display stuck high: without the guard the host never gets in
        grants = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, '0);
            if (host_gnt) grants++;
        end
        checkOutput("t4_no_gnt_while_disp_busy", 32'(grants), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0200, '0);
        checkOutput("t4_gnt_after_disp_drop", 32'(host_gnt), 32'd1);
        idle();
        checkOutput("t4_host_rdata", 32'(host_rdata), 32'h02);
`endif

        // Reset in the cycle after a host read grant discards the response
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0010, '0);
        checkOutput("t5_gnt", 32'(host_gnt), 32'd1);
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        host_req = 1'b0;
        @(negedge clk);
        checkOutput("t5_rvalid_in_reset", 32'(host_rvalid), 32'd0);
        checkOutput("t5_sram_en_in_reset", 32'(sram_en),    32'd0);
        idle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_rvalid_after_release", 32'(host_rvalid), 32'd0);
        checkOutput("t5_dvalid_after_release", 32'(disp_valid),  32'd0);
        idle();

        // Alternating display and host reads at random addresses
        for (int i = 0; i < 1000; i++) begin
            da = AW'($urandom_range(0, (1 << AW) - 1));
            if (i % 2 == 0) applyStimulus(1'b1, da, 1'b0, 1'b0, '0, '0);
            else            applyStimulus(1'b0, '0, 1'b1, 1'b0, da, '0);
        end

        // Random mix with host writes and contention, host holds until granted
        h_hold = 1'b0;
        hr = 1'b0; hw = 1'b0; ha = '0; hd = '0;
        for (int i = 0; i < 300; i++) begin
            dr = 1'($urandom_range(0, 1));
            da = AW'($urandom_range(0, 63));
            if (!h_hold) begin
                hr = 1'($urandom_range(0, 1));
                hw = ($urandom_range(0, 3) == 0);
                ha = AW'($urandom_range(0, 63));
                hd = DW'($urandom_range(0, 255));
            end
            applyStimulus(dr, da, hr, hw, ha, hd);
            h_hold = hr && !host_gnt;
        end
        if (h_hold) applyStimulus(1'b0, '0, 1'b1, hw, ha, hd);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
